// File: rtl/k_alu_shift_pipe.sv
// k_alu_shift_pipe: pipelined barrel shifter, one shift-amount bit per stage.
// Define KALU_SHIFT_ROTATE_EN to build op 11 as rotate right.
module k_alu_shift_pipe #(
    parameter  int WIDTH = 8,
    parameter  int TAG_W = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_amt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef struct packed {
        logic             v;
        logic [1:0]       op;
        logic [SHW-1:0]   amt;
        logic             sgn;
        logic             c;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] d;
    } stg_t;

    logic stall;

    for (genvar k = 0; k < SHW; k++) begin : g_stg
        localparam int SH = 1 << k;

        stg_t src;
        stg_t nxt;
        stg_t st_q;
        logic is_sll;
        logic is_srl;
        logic is_sra;
        logic is_ror;

        if (k == 0) begin : g_head
            always_comb begin
                src     = '0;
                src.v   = in_valid;
                src.op  = in_op;
                src.amt = in_amt;
                src.sgn = in_a[WIDTH-1];
                src.c   = 1'b0;
                src.tag = in_tag;
                src.d   = in_a;
            end
        end else begin : g_body
            assign src = g_stg[k-1].st_q;
        end

        assign is_sll = (src.op == OP_SLL);
        assign is_srl = (src.op == OP_SRL);
        assign is_sra = (src.op == OP_SRA);
        assign is_ror = (src.op == OP_ROR);

        always_comb begin
            nxt = src;
            if (src.amt[k]) begin
                unique case (1'b1)
                    is_sll: begin
                        nxt.d = {src.d[WIDTH-SH-1:0], {SH{1'b0}}};
                        nxt.c = src.d[WIDTH-SH];
                    end
                    is_srl: begin
                        nxt.d = {{SH{1'b0}}, src.d[WIDTH-1:SH]};
                        nxt.c = src.d[SH-1];
                    end
                    is_sra: begin
                        nxt.d = {{SH{src.sgn}}, src.d[WIDTH-1:SH]};
                        nxt.c = src.d[SH-1];
                    end
`ifdef KALU_SHIFT_ROTATE_EN
                    is_ror: begin
                        // carry is the new MSB, i.e. the bit wrapped around
                        nxt.d = {src.d[SH-1:0], src.d[WIDTH-1:SH]};
                        nxt.c = src.d[SH-1];
                    end
`else
                    is_ror: begin
                        nxt.d = src.d;
                        nxt.c = src.c;
                    end
`endif
                    default: begin
                        nxt.d = src.d;
                        nxt.c = src.c;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q <= '0;
            end else if (!stall) begin
                st_q.v <= nxt.v;
                if (nxt.v) begin
                    st_q <= nxt;
                end
            end
        end
    end

    assign out_valid = g_stg[SHW-1].st_q.v;
    assign out_res   = g_stg[SHW-1].st_q.d;
    assign out_carry = g_stg[SHW-1].st_q.c;
    assign out_tag   = g_stg[SHW-1].st_q.tag;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    logic unused_tail;
    assign unused_tail = ^{g_stg[SHW-1].st_q.op,
                           g_stg[SHW-1].st_q.amt,
                           g_stg[SHW-1].st_q.sgn};

endmodule
